// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result bit per SHIFT cycle.
// valid pulses WIDTH+1 cycles after start is accepted; start is ignored while busy.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      binary,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic                  busy,
  output logic                  valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [4*DIGITS-1:0]   dig_q;
  logic [WIDTH-1:0]      mag_q;
  logic [CW-1:0]         cnt_q;
  logic                  carry_q;
  logic                  sign_q;

  logic [4*DIGITS-1:0]   bcd_q;
  logic                  negative_q;
  logic                  overflow_q;
  logic                  busy_q;
  logic                  valid_q;

  logic [4*DIGITS-1:0]   dig_corr;
  logic [4*DIGITS-1:0]   dig_d;
  logic [WIDTH-1:0]      mag_d;
  logic [WIDTH-1:0]      mag_load_d;
  logic                  carry_out;
  logic                  sign_load_d;

  // Add-3 correction so that the following doubling carries correctly into the next digit.
  always_comb begin
    dig_corr = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) begin
        dig_corr[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Bit leaving the top digit carries weight 10^DIGITS, hence it marks overflow.
  assign {carry_out, dig_d, mag_d} = {dig_corr, mag_q, 1'b0};

  assign sign_load_d = signed_mode & binary[WIDTH-1];
  assign mag_load_d  = sign_load_d ? (~binary + WIDTH'(1)) : binary;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dig_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            mag_q   <= mag_load_d;
            dig_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            carry_q <= 1'b0;
            sign_q  <= sign_load_d;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          dig_q <= dig_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q - CW'(1);
          if (carry_out) begin
            carry_q <= 1'b1;
          end
          // Results are registered on the last shift so they appear exactly in DONE.
          if (cnt_q == CW'(1)) begin
            state_q    <= DONE;
            bcd_q      <= dig_d;
            negative_q <= sign_q;
            overflow_q <= carry_q | carry_out;
            valid_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign negative = negative_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two instances (32/10 and 16/4) against an arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start_s [2];
  logic        sgn_s [2];
  logic [31:0] bin_s [2];

  logic [39:0] a_bcd;
  logic        a_neg, a_ovf, a_busy, a_valid;
  logic [15:0] b_bcd;
  logic        b_neg, b_ovf, b_busy, b_valid;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut_a (
    .clock(clock), .resetn(resetn), .start(start_s[0]), .signed_mode(sgn_s[0]),
    .binary(bin_s[0]), .bcd(a_bcd), .negative(a_neg), .overflow(a_ovf),
    .busy(a_busy), .valid(a_valid)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut_b (
    .clock(clock), .resetn(resetn), .start(start_s[1]), .signed_mode(sgn_s[1]),
    .binary(bin_s[1][15:0]), .bcd(b_bcd), .negative(b_neg), .overflow(b_ovf),
    .busy(b_busy), .valid(b_valid)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // {valid, busy, negative, overflow, zero-extended bcd}
  function automatic logic [83:0] act_out(input int i);
    if (i == 0) return {a_valid, a_busy, a_neg, a_ovf, 40'd0, a_bcd};
    return {b_valid, b_busy, b_neg, b_ovf, 64'd0, b_bcd};
  endfunction

  // Reference result {negative, overflow, bcd[79:0]} from plain arithmetic.
  function automatic logic [81:0] expect_res(input int w, input int d,
                                             input logic [31:0] bin, input logic sgn);
    longint unsigned v, mag, lim, m;
    logic [79:0] b;
    logic neg;
    v   = longint'(bin) & ((64'd1 << w) - 64'd1);
    neg = sgn && v[w-1];
    mag = neg ? ((64'd1 << w) - v) : v;
    lim = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    m = mag % lim;
    b = '0;
    for (int k = 0; k < d; k++) begin
      b[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {neg, (mag >= lim), b};
  endfunction

  // Timeline model: an accepted request keeps the unit busy WIDTH+1 cycles, result on the last.
  int          left [2];
  logic [81:0] e_res [2];
  logic [81:0] p_res [2];
  int          WW [2] = '{32, 16};
  int          DD [2] = '{10, 4};

  initial begin
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; e_res[i] = '0; p_res[i] = '0;
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        left[i] = 0; e_res[i] = '0; p_res[i] = '0;
      end else if (left[i] == 0) begin
        if (start_s[i]) begin
          p_res[i] = expect_res(WW[i], DD[i], bin_s[i], sgn_s[i]);
          left[i]  = WW[i] + 1;
        end
      end else begin
        left[i]--;
        if (left[i] == 1) e_res[i] = p_res[i];
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("outputs_dut%0d", i), act_out(i), {left[i] == 1, left[i] > 0, e_res[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pick_val(input int i);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      2: return (i == 0) ? 32'h8000_0000 : 32'h0000_8000;
      3: return 32'($urandom_range(0, 999));
      default: return $urandom;
    endcase
  endfunction

  task automatic start_conv(input int i, input logic [31:0] bin, input logic sgn);
    start_s[i] = 1'b1;
    bin_s[i]   = bin;
    sgn_s[i]   = sgn;
    tick();
    start_s[i] = 1'b0;
    bin_s[i]   = $urandom;
    sgn_s[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input int i, output int n, output logic [83:0] r);
    logic [83:0] a;
    n = 0;
    r = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      a = act_out(i);
      if (a[83]) begin
        n = c;
        r = a;
        break;
      end
    end
  endtask

  task automatic run(input int i, input logic [31:0] bin, input logic sgn,
                     output int n, output logic [83:0] r);
    repeat (2) tick();
    start_conv(i, bin, sgn);
    wait_valid(i, n, r);
  endtask

  initial begin
    int n;
    int vcnt;
    int last;
    logic [83:0] r;
    logic [83:0] a;
    logic [39:0] cap;

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; sgn_s[i] = 1'b0; bin_s[i] = '0;
    end
    tick();
    chk_en = 1'b1;

    // start coincident with reset is ignored, then accepted on the first released edge
    start_s[0] = 1'b1; bin_s[0] = 32'hFFFF_FFFF; sgn_s[0] = 1'b0;
    tick();
    @(negedge clock);
    a = act_out(0);
    chk("start_in_reset_busy", {83'd0, a[82]}, 84'd0);
    resetn = 1'b1;
    tick();
    start_s[0] = 1'b0;
    wait_valid(0, n, r);
    chk("max_unsigned_latency", 84'(n), 84'd33);
    chk("max_unsigned_bcd", {44'd0, r[39:0]}, 84'h42_9496_7295);
    chk("max_unsigned_neg_ovf", {82'd0, r[81:80]}, 84'd0);
    @(negedge clock);
    a = act_out(0);
    chk("busy_low_after_done", {83'd0, a[82]}, 84'd0);

    run(0, 32'hFFFF_FFFF, 1'b1, n, r);
    chk("signed_minus1_bcd", {44'd0, r[39:0]}, 84'd1);
    chk("signed_minus1_neg", {83'd0, r[81]}, 84'd1);
    run(0, 32'h8000_0000, 1'b1, n, r);
    chk("signed_min_bcd", {44'd0, r[39:0]}, 84'h21_4748_3648);
    chk("signed_min_neg_ovf", {82'd0, r[81:80]}, 84'b10);
    run(0, 32'd0, 1'b1, n, r);
    chk("signed_zero", {42'd0, r[81:80], r[39:0]}, 84'd0);

    run(1, 32'd12345, 1'b0, n, r);
    chk("small_latency", 84'(n), 84'd17);
    chk("small_ovf_bcd", {68'd0, r[15:0]}, 84'h2345);
    chk("small_ovf_flag", {83'd0, r[80]}, 84'd1);
    run(1, 32'd9999, 1'b0, n, r);
    chk("small_9999", {66'd0, r[81:80], r[15:0]}, 84'h9999);

    // start pulse while a conversion is in flight is dropped
    repeat (2) tick();
    start_conv(0, 32'd255, 1'b0);
    repeat (3) tick();
    start_s[0] = 1'b1; bin_s[0] = 32'd99;
    tick();
    start_s[0] = 1'b0;
    vcnt = 0; cap = '0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (a_valid) begin vcnt++; cap = a_bcd; end
    end
    chk("ignored_start_valids", 84'(vcnt), 84'd1);
    chk("ignored_start_bcd", {44'd0, cap}, 84'h255);
    a = act_out(0);
    chk("ignored_start_busy", {83'd0, a[82]}, 84'd0);

    // reset mid-conversion aborts it
    repeat (2) tick();
    start_conv(0, 32'd12345678, 1'b0);
    repeat (8) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clock);
    chk("reset_abort_outputs", act_out(0), 84'd0);
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (a_valid) vcnt++;
    end
    chk("reset_abort_no_valid", 84'(vcnt), 84'd0);
    run(0, 32'd0, 1'b0, n, r);
    chk("zero_after_reset_latency", 84'(n), 84'd33);
    chk("zero_after_reset_bcd", {44'd0, r[39:0]}, 84'd0);

    // start held high: one accept every WIDTH+2 cycles
    repeat (2) tick();
    vcnt = 0; last = -1;
    for (int c = 0; c < 180; c++) begin
      start_s[0] = 1'b1;
      bin_s[0]   = $urandom;
      sgn_s[0]   = 1'($urandom_range(0, 1));
      tick();
      @(negedge clock);
      if (a_valid) begin
        vcnt++;
        if (last >= 0) chk("back_to_back_gap", 84'(c - last), 84'd34);
        last = c;
      end
    end
    start_s[0] = 1'b0;
    chk("back_to_back_count", 84'(vcnt), 84'd5);

    // random traffic on both instances with occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        start_s[i] = ($urandom_range(0, 3) == 0);
        bin_s[i]   = pick_val(i);
        sgn_s[i]   = 1'($urandom_range(0, 1));
      end
      resetn = ($urandom_range(0, 599) != 0);
      tick();
    end
    resetn = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (40) tick();
    @(negedge clock);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the binary input width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter DIGITS, default 10, giving the number of BCD output digits (legal range 1..20).
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: conversion request, sampled on clock edge.
REQ-006 Port signed_mode, input, 1: when 1, binary is two's complement; sampled with start.
REQ-007 Port binary, input, WIDTH: value to convert; sampled with start.
REQ-008 Port bcd, output, 4*DIGITS: result; digit k at bits [4k+3:4k], digit 0 least significant.
REQ-009 Port negative, output, 1: result sign (1 = input was negative in signed mode).
REQ-010 Port overflow, output, 1: magnitude exceeded 10^DIGITS-1; bcd holds the value modulo 10^DIGITS.
REQ-011 Port busy, output, 1: high while a conversion is in progress.
REQ-012 Port valid, output, 1: single-cycle pulse marking new bcd/negative/overflow.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted; the FSM then enters SHIFT on the same edge.
REQ-015 On accept, the block SHALL load:
- magnitude register = binary, or its two's-complement negation when signed_mode=1 and binary[WIDTH-1]=1;
- internal digit registers = 0;
- bit counter = WIDTH;
- sticky carry flag = 0;
- sign = signed_mode AND binary[WIDTH-1].
REQ-016 The magnitude register SHALL be WIDTH bits unsigned, so -2^(WIDTH-1) converts to magnitude 2^(WIDTH-1) without loss.
REQ-017 Each SHIFT cycle SHALL:
- add 3 to every internal digit >= 5;
- shift the digit chain plus magnitude left by one, the magnitude MSB entering digit 0 bit 0;
- decrement the bit counter.
REQ-018 The bit shifted out of digit DIGITS-1 bit 3 SHALL set the sticky carry flag.
REQ-019 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-020 In DONE, the block SHALL copy the internal digits, sign and sticky carry flag to bcd, negative and overflow, pulse valid for that one cycle, and return to IDLE on the next edge.
REQ-021 Latency from the start-accept edge to valid high SHALL be WIDTH+1 cycles; throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-022 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-023 start asserted in SHIFT or DONE SHALL be ignored: not queued, no effect on the conversion in flight.
REQ-024 bcd, negative and overflow SHALL hold their last values until the next DONE, and SHALL NOT change mid-conversion.
REQ-025 binary and signed_mode changes after the accept edge SHALL NOT affect the result.
REQ-026 Zero input SHALL give bcd=0 and negative=0 in both modes.

Reset
REQ-027 When resetn=0 at a clock edge, the block SHALL set:
- FSM to IDLE;
- bcd, negative, overflow, busy and valid to 0;
- internal digits, magnitude, counter and flags to 0.
REQ-028 Reset during SHIFT or DONE SHALL abort the conversion with no valid pulse.
REQ-029 start coincident with resetn=0 SHALL be ignored.
REQ-030 The first start SHALL be accepted on the first edge with resetn=1.

Verification (WIDTH=32, DIGITS=10 unless stated)
REQ-031 Unsigned 4294967295 start -> valid exactly 33 cycles later, bcd=0x4294967295, negative=0, overflow=0, busy high for cycles 1..33.
REQ-032 signed_mode=1, binary=0xFFFFFFFF -> bcd=0x0000000001, negative=1; binary=0x80000000 -> bcd=0x2147483648, negative=1.
REQ-033 DIGITS=4, WIDTH=16, unsigned 12345 -> bcd=0x2345, overflow=1; then 9999 -> bcd=0x9999, overflow=0.
REQ-034 Convert 255, then pulse start with 99 at cycle 5 of the conversion -> single valid, bcd=0x255, and busy falls with no second conversion.
REQ-035 resetn=0 at cycle 10 of a conversion -> no valid, all outputs 0, next start with 0 -> bcd=0, valid after 33 cycles.
REQ-036 Back-to-back starts held high continuously -> a conversion is accepted every 34 cycles, each with a correct result.
